// File: rtl/branch_hazard_unit.sv
// Branch operand hazard/forwarding controller for the ID-stage comparator.
// Tracks destination tags of EX/MEM/WB. It selects the forwarding source for each
// branch operand, or it stalls while a load result is still in flight.
module branch_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  output logic [3:0]       forward_c,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_LD_EX  = 2'b01,
    HZ_LD_MEM = 2'b10,
    HZ_FROZEN = 2'b11
  } hz_state_t;

  hz_state_t        state_q;

  logic             ex_we, mem_we, wb_we;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ex_ld, mem_ld, wb_ld;

  logic [3:0]       res_rs1, res_rs2;
  logic             ld_hazard, hazard_in_ex;
  logic [3:0]       fwd_raw;

  // Resolution word for one source: {hazard_from_ex, hazard, select[1:0]}.
  function automatic logic [3:0] resolve(
    input logic [REG_W-1:0] src,
    input logic             use_src,
    input logic             e_we, input logic [REG_W-1:0] e_rd, input logic e_ld,
    input logic             m_we, input logic [REG_W-1:0] m_rd, input logic m_ld,
    input logic             w_we, input logic [REG_W-1:0] w_rd,
    input logic             valid, input logic branch
  );
    logic live;
    logic hit_ex, hit_mem, hit_wb;
    live    = valid & branch & use_src & ~((ZERO_REG != 0) && (src == '0));
    hit_ex  = live & e_we & (e_rd == src);
    hit_mem = live & m_we & (m_rd == src);
    hit_wb  = live & w_we & (w_rd == src);
    resolve = 4'b0000;
    if (hit_ex)       resolve = e_ld ? 4'b1100 : 4'b0001;
    else if (hit_mem) resolve = m_ld ? 4'b0100 : 4'b0010;
    else if (hit_wb)  resolve = 4'b0011;
  endfunction

  // Per-source forwarding select and load-use hazard detection.
  always_comb begin
    res_rs1 = resolve(id_rs1, id_use_rs1, ex_we, ex_rd, ex_ld, mem_we, mem_rd, mem_ld,
                      wb_we, wb_rd, id_valid, id_is_branch);
    res_rs2 = resolve(id_rs2, id_use_rs2, ex_we, ex_rd, ex_ld, mem_we, mem_rd, mem_ld,
                      wb_we, wb_rd, id_valid, id_is_branch);
    ld_hazard    = res_rs1[2] | res_rs2[2];
    hazard_in_ex = res_rs1[3] | res_rs2[3];
    fwd_raw      = {res_rs2[1:0], res_rs1[1:0]};
  end

  // Stall/bubble control; forwarding is suppressed while waiting on a load.
  always_comb begin
    stall_id  = ld_hazard | stall_in;
    bubble_ex = ld_hazard & ~stall_in;
    forward_c = ld_hazard ? 4'b0000 : fwd_raw;
  end

  assign hz_state = state_q;

  // Tag pipeline advance, hazard state and saturating stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_we       <= 1'b0;
      ex_rd       <= '0;
      ex_ld       <= 1'b0;
      mem_we      <= 1'b0;
      mem_rd      <= '0;
      mem_ld      <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_ld       <= 1'b0;
      state_q     <= HZ_RUN;
      stall_count <= '0;
    end else if (stall_in) begin
      state_q <= HZ_FROZEN;
    end else begin
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      mem_ld <= ex_ld;
      wb_we  <= mem_we;
      wb_rd  <= mem_rd;
      wb_ld  <= mem_ld;
      if (ld_hazard) begin
        ex_we   <= 1'b0;
        ex_rd   <= '0;
        ex_ld   <= 1'b0;
        state_q <= hazard_in_ex ? HZ_LD_EX : HZ_LD_MEM;
        if (stall_count != '1)
          stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ex_we   <= id_we & id_valid;
        ex_rd   <= id_rd;
        ex_ld   <= id_is_load;
        state_q <= HZ_RUN;
      end
    end
  end

endmodule
